// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
//   Byte-addressable data memory for the RV32I core with one memory-mapped
//   LED register. Byte, halfword and word loads/stores are served by a small
//   read-modify-write FSM; clk_stall holds the pipeline for the two cycles an
//   access takes.
//
//   Ports
//     clk          in   1   clock, rising edge
//     rst_n        in   1   asynchronous active-low reset
//     addr         in  32   byte address
//     write_data   in  32   store data (byte/half data in the low bits)
//     memwrite     in   1   store request (wins over memread)
//     memread      in   1   load request
//     sign_mask    in   4   [3] sign-extend load, [2:0] 001 byte/011 half/111 word
//     read_data    out 32   load result, extended to 32 bits
//     led          out  8   LED register
//     clk_stall    out  1   high while an access is in progress
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; request fields are latched here
//   FETCH | RAM word containing the addressed lane is read into word_buf
//   READ  | lane selected/extended into read_data, stall released
//   WRITE | merged word written back (or LED updated), stall released
// ---------------------------------------------------------------------------
module data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = 32'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic [7:0]  led,
    output logic        clk_stall
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        store_q, store_d;
    logic [31:0] read_data_q, read_data_d;
    logic [7:0]  led_q, led_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] word_buf_q;

    logic [AW-1:0] idx;
    logic          in_ram;
    logic          is_led;
    logic          is_word;
    logic          is_half;
    logic          mem_we;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   merged;

    // Address decode and lane handling on the latched request
    always_comb begin
        idx     = addr_q[AW+1:2];
        in_ram  = (addr_q < RAM_BYTES);
        is_led  = (addr_q == LED_ADDR);
        is_word = mask_q[2];
        is_half = ~mask_q[2] & mask_q[1];
        lane_b  = word_buf_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h  = word_buf_q[{addr_q[1], 4'b0000} +: 16];

        load_val = 32'h0;
        if (in_ram) begin
            if (is_word) begin
                load_val = word_buf_q;
            end else if (is_half) begin
                load_val = {{16{mask_q[3] & lane_h[15]}}, lane_h};
            end else begin
                load_val = {{24{mask_q[3] & lane_b[7]}}, lane_b};
            end
        end else if (is_led) begin
            // LED reads are never lane-selected or sign-extended
            load_val = {24'h0, led_q};
        end

        merged = word_buf_q;
        if (is_word) begin
            merged = wdata_q;
        end else if (is_half) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        store_d     = store_q;
        read_data_d = read_data_q;
        led_d       = led_q;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (memwrite || memread) begin
                    addr_d  = addr;
                    wdata_d = write_data;
                    mask_d  = sign_mask;
                    store_d = memwrite;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = store_q ? WRITE : READ;
            end
            READ: begin
                read_data_d = load_val;
                state_d     = IDLE;
            end
            WRITE: begin
                mem_we = in_ram;
                if (is_led) begin
                    led_d = wdata_q[7:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            mask_q      <= 4'h0;
            store_q     <= 1'b0;
            read_data_q <= 32'h0;
            led_q       <= 8'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            store_q     <= store_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
        end
    end

    // RAM array and read buffer carry no reset so the array maps onto block RAM.
    // A reset drops state_q to IDLE, which gates off any pending write.
    always_ff @(posedge clk) begin
        if (state_q == FETCH) begin
            word_buf_q <= mem[idx];
        end
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    assign read_data = read_data_q;
    assign led       = led_q;
    assign clk_stall = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [3:0]  sign_mask = 4'h0;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic        clk_stall;

    int n_vec  = 0;
    int n_miss = 0;
    bit started = 1'b0;

    data_mem #(.DEPTH_WORDS(1024), .LED_ADDR(32'h2000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .led        (led),
        .clk_stall  (clk_stall)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte-addressed memory, an access completes two
    // rising edges after it is accepted, requests while busy are dropped.
    logic [7:0]  mb [0:4095];
    int          m_busy = 0;
    logic [31:0] m_rd = 32'h0;
    logic [7:0]  m_led = 8'h0;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_mask;
    bit          p_store;

    task automatic model_apply();
        int n;
        int off;
        int base;
        logic [31:0] v;
        n    = p_mask[2] ? 4 : (p_mask[1] ? 2 : 1);
        off  = p_mask[2] ? 0 : (p_mask[1] ? (p_addr[1] ? 2 : 0) : int'(p_addr[1:0]));
        base = int'({p_addr[11:2], 2'b00}) + off;
        if (p_store) begin
            if (p_addr < 32'd4096) begin
                for (int i = 0; i < n; i++) mb[base + i] = p_wdata[8*i +: 8];
            end else if (p_addr == 32'h2000) begin
                m_led = p_wdata[7:0];
            end
        end else begin
            if (p_addr < 32'd4096) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
                if (p_mask[3] && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
                m_rd = v;
            end else if (p_addr == 32'h2000) begin
                m_rd = {24'h0, m_led};
            end else begin
                m_rd = 32'h0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_rd   = 32'h0;
            m_led  = 8'h0;
        end else if (m_busy == 0) begin
            if (memwrite || memread) begin
                p_addr  = addr;
                p_wdata = write_data;
                p_mask  = sign_mask;
                p_store = memwrite;
                m_busy  = 2;
            end
        end else begin
            m_busy = m_busy - 1;
            if (m_busy == 0) model_apply();
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            n_vec++;
            if (read_data !== m_rd || led !== m_led || clk_stall !== (m_busy != 0)) begin
                n_miss++;
                $display("FAIL cycle_cmp t=%0t rd=%h/%h led=%h/%h stall=%b/%b (actual/required)",
                         $time, read_data, m_rd, led, m_led, clk_stall, (m_busy != 0));
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One access; optionally a stray request is driven during the stall.
    task automatic access(input bit st, input bit ld, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m,
                          input bit intrude, input logic [31:0] ia);
        int cnt;
        @(negedge clk);
        memwrite   = st;
        memread    = ld;
        addr       = a;
        write_data = wd;
        sign_mask  = m;
        @(negedge clk);
        if (intrude) begin
            memread    = 1'b1;
            memwrite   = 1'($urandom_range(0, 1));
            addr       = ia;
            write_data = $urandom;
            sign_mask  = 4'($urandom_range(0, 15));
        end else begin
            memwrite   = 1'b0;
            memread    = 1'b0;
            addr       = $urandom;
            write_data = $urandom;
        end
        cnt = 0;
        while (clk_stall && cnt < 10) begin
            cnt++;
            @(negedge clk);
            memwrite = 1'b0;
            memread  = 1'b0;
        end
        check("stall_cycles", 32'(cnt), 32'd2);
    endtask

    logic [31:0] ra, rw;
    logic [3:0]  rm;
    bit          rst_, rld;

    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        started = 1'b1;
        check("reset_read_data", read_data, 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_stall", 32'(clk_stall), 32'h0);

        // Give the exercised RAM words defined contents
        for (int w = 0; w < 16; w++) access(1, 0, 32'(w * 4), 32'h0, 4'b0111, 0, 0);
        access(1, 0, 32'hffc, 32'h0, 4'b0111, 0, 0);

        access(1, 0, 32'h4, 32'hff03ab21, 4'b0111, 0, 0);
        access(0, 1, 32'h4, 32'h0, 4'b0111, 0, 0);
        check("word_load_4", read_data, 32'hff03ab21);

        access(1, 0, 32'h8, 32'h0000ab21, 4'b0011, 0, 0);
        access(0, 1, 32'h8, 32'h0, 4'b1011, 0, 0);
        check("half_signed_8", read_data, 32'hffffab21);
        access(0, 1, 32'h8, 32'h0, 4'b0011, 0, 0);
        check("half_unsigned_8", read_data, 32'h0000ab21);

        access(1, 0, 32'h13, 32'h00000053, 4'b0001, 0, 0);
        access(0, 1, 32'h13, 32'h0, 4'b0001, 0, 0);
        check("byte_unsigned_13", read_data, 32'h00000053);
        access(0, 1, 32'h13, 32'h0, 4'b1001, 0, 0);
        check("byte_signed_13", read_data, 32'h00000053);
        access(0, 1, 32'h4, 32'h0, 4'b0111, 0, 0);
        check("word_load_4_again", read_data, 32'hff03ab21);

        access(1, 0, 32'h8, 32'habababab, 4'b0111, 1, 32'h4);
        check("ignored_load_rd", read_data, 32'hff03ab21);
        access(0, 1, 32'h8, 32'h0, 4'b0111, 0, 0);
        check("word_load_8", read_data, 32'habababab);

        access(1, 0, 32'h2000, 32'habababab, 4'b0111, 0, 0);
        check("led_store", 32'(led), 32'h000000ab);
        access(0, 1, 32'h2000, 32'h0, 4'b0111, 0, 0);
        check("led_load", read_data, 32'h000000ab);

        // Reset in the middle of a store
        @(negedge clk);
        memwrite = 1'b1; addr = 32'h8; write_data = 32'h12345678; sign_mask = 4'b0111;
        @(negedge clk);
        memwrite = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_stall", 32'(clk_stall), 32'h0);
        check("midrst_rd", read_data, 32'h0);
        check("midrst_led", 32'(led), 32'h0);
        #2 rst_n = 1'b1;
        access(0, 1, 32'h8, 32'h0, 4'b0111, 0, 0);
        check("midrst_ram_kept", read_data, 32'habababab);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ra = 32'($urandom_range(0, 63));
                6: ra = 32'hffc + 32'($urandom_range(0, 3));
                7: ra = 32'h2000;
                8: ra = ($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h2001;
                default: ra = $urandom | 32'h0001_0000;
            endcase
            rw   = $urandom;
            rm   = 4'($urandom_range(0, 15));
            rst_ = ($urandom_range(0, 1) != 0);
            rld  = rst_ ? ($urandom_range(0, 1) != 0) : 1'b1;
            access(rst_, rld, ra, rw, rm, ($urandom_range(0, 3) == 0),
                   32'($urandom_range(0, 63)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
